// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and oversampling ratio.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_if.sv
// Serial-side and word-side signals of the UART receiver.
interface uart_rx_if #(
    parameter int unsigned DBIT = 8
) ();

    logic            s_tick;
    logic            rx;
    logic [DBIT-1:0] dout;
    logic            rx_done_tick;
    logic            frame_err;

    // Tick source / serial line driver and word consumer.
    modport master (
        output s_tick,
        output rx,
        input  dout,
        input  rx_done_tick,
        input  frame_err
    );

    // Receiver.
    modport slave (
        input  s_tick,
        input  rx,
        output dout,
        output rx_done_tick,
        output frame_err
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start/data/stop recovery with framing check.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);

    // s is 5 bits wide so it can count all stop ticks up to 2 stop bits.
    localparam int unsigned S_W = 5;
    localparam int unsigned N_W = $clog2(DBIT);

    logic            rx_s;
    rx_state_t       state;
    rx_state_t       state_n;
    logic [S_W-1:0]  s;
    logic [S_W-1:0]  s_n;
    logic [N_W-1:0]  n;
    logic [N_W-1:0]  n_n;
    logic [DBIT-1:0] b;
    logic [DBIT-1:0] b_n;
    logic            stop_bit;
    logic            stop_bit_n;
    logic            done_c;

    logic            mid_c;
    logic            last_c;
    logic            stop_end_c;
    logic            last_bit_c;

    sync_2ff #(
        .RST_VAL(1'b1)
    ) u_sync_rx (
        .clk(clk),
        .rst(rst),
        .d  (bus.rx),
        .q  (rx_s)
    );

    assign mid_c      = (s == S_W'(OVERSAMPLE / 2 - 1));
    assign last_c     = (s == S_W'(OVERSAMPLE - 1));
    assign stop_end_c = (s == S_W'(SB_TICK - 1));
    assign last_bit_c = (n == N_W'(DBIT - 1));

    // State, counters, shift register and registered word outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            s                <= '0;
            n                <= '0;
            b                <= '0;
            stop_bit         <= 1'b0;
            bus.dout         <= '0;
            bus.frame_err    <= 1'b0;
            bus.rx_done_tick <= 1'b0;
        end else begin
            state            <= state_n;
            s                <= s_n;
            n                <= n_n;
            b                <= b_n;
            stop_bit         <= stop_bit_n;
            bus.rx_done_tick <= done_c;
            if (done_c) begin
                bus.dout      <= b;
                bus.frame_err <= ~stop_bit_n;
            end
        end
    end

    // Next-state decode; only IDLE->START happens off an s_tick.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (!rx_s) state_n = START;
            START: if (bus.s_tick && mid_c) state_n = rx_s ? IDLE : DATA;
            DATA:  if (bus.s_tick && last_c && last_bit_c) state_n = STOP;
            STOP:  if (bus.s_tick && stop_end_c) state_n = IDLE;
        endcase
    end

    // Counter, shift and completion updates for the current state.
    always_comb begin
        s_n        = s;
        n_n        = n;
        b_n        = b;
        stop_bit_n = stop_bit;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) s_n = '0;
            end
            START: begin
                if (bus.s_tick) begin
                    if (mid_c) begin
                        s_n = '0;
                        n_n = '0;
                    end else begin
                        s_n = s + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (bus.s_tick) begin
                    if (last_c) begin
                        s_n = '0;
                        b_n = {rx_s, b[DBIT-1:1]};
                        if (!last_bit_c) n_n = n + N_W'(1);
                    end else begin
                        s_n = s + S_W'(1);
                    end
                end
            end
            STOP: begin
                if (bus.s_tick) begin
                    // Mid-point of the first stop bit decides framing.
                    if (last_c) stop_bit_n = rx_s;
                    if (stop_end_c) begin
                        s_n    = '0;
                        done_c = 1'b1;
                    end else begin
                        s_n = s + S_W'(1);
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: 8N1 (DBIT=8, 1 stop) and DBIT=7 with 2 stop bits.
module tb_uart_rx;

    localparam int BIT_CLK = 64;   // 16 s_ticks of 4 clk each
    localparam int LAT_MIN = 600;  // frame = 152 ticks (~608 clk) from rx fall to strobe
    localparam int LAT_MAX = 620;

    typedef struct {
        logic [8:0] data;
        logic       fe;
        int         t0;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;

    int n_cmp = 0;
    int n_err = 0;

    exp_t q8[$];
    exp_t q7[$];
    int   pushed8 = 0;
    int   pushed7 = 0;
    int   strobes8 = 0;
    int   strobes7 = 0;
    logic prev8 = 1'b0;
    logic prev7 = 1'b0;

    uart_rx_if #(.DBIT(8)) b8 ();
    uart_rx_if #(.DBIT(7)) b7 ();

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut8 (
        .clk(clk),
        .rst(rst),
        .bus(b8)
    );

    uart_rx #(.DBIT(7), .SB_TICK(32)) dut7 (
        .clk(clk),
        .rst(rst),
        .bus(b7)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Baud generator stand-in: one s_tick every 4 clk.
    initial begin
        int ph;
        ph = 0;
        b8.s_tick = 1'b0;
        b7.s_tick = 1'b0;
        forever begin
            @(negedge clk);
            b8.s_tick = (ph == 3);
            b7.s_tick = (ph == 3);
            ph = (ph + 1) % 4;
        end
    end

    function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endfunction

    task automatic check_frame(input string nm, input exp_t e, input logic [8:0] got_d,
                               input logic got_fe, input logic prev);
        int lat;
        lat = cyc - e.t0;
        chk({nm, "_dout"}, 32'(got_d), 32'(e.data));
        chk({nm, "_frame_err"}, 32'(got_fe), 32'(e.fe));
        chk({nm, "_strobe_one_cycle"}, 32'(prev), 32'(0));
        n_cmp++;
        if (lat < LAT_MIN || lat > LAT_MAX) begin
            n_err++;
            $display("FAIL %s_latency: got %0d clk expected %0d..%0d", nm, lat, LAT_MIN, LAT_MAX);
        end
    endtask

    // Monitor for the DBIT=8 receiver.
    always @(negedge clk) begin
        if (b8.rx_done_tick === 1'b1) begin
            strobes8++;
            if (q8.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL dut8_unexpected_strobe: got dout=0x%0h fe=%b expected no strobe",
                         b8.dout, b8.frame_err);
            end else begin
                check_frame("dut8", q8.pop_front(), 9'(b8.dout), b8.frame_err, prev8);
            end
        end
        prev8 = b8.rx_done_tick;
    end

    // Monitor for the DBIT=7 receiver.
    always @(negedge clk) begin
        if (b7.rx_done_tick === 1'b1) begin
            strobes7++;
            if (q7.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL dut7_unexpected_strobe: got dout=0x%0h fe=%b expected no strobe",
                         b7.dout, b7.frame_err);
            end else begin
                check_frame("dut7", q7.pop_front(), 9'(b7.dout), b7.frame_err, prev7);
            end
        end
        prev7 = b7.rx_done_tick;
    end

    task automatic set_rx(input bit sel7, input logic v);
        if (sel7) b7.rx = v;
        else      b8.rx = v;
    endtask

    // Hold the line at v for nclk clocks; call and return on a negedge.
    task automatic hold_rx(input bit sel7, input logic v, input int nclk);
        set_rx(sel7, v);
        repeat (nclk) @(negedge clk);
    endtask

    // Serialise one frame LSB first; the expected word is what the line carried.
    task automatic send_frame(input bit sel7, input logic [8:0] data, input int nbits,
                              input logic stop_val, input int stop_clk, input bit expect_it);
        exp_t       e;
        logic [8:0] mask;
        mask   = 9'((1 << nbits) - 1);
        e.data = data & mask;
        e.fe   = ~stop_val;
        e.t0   = cyc;
        if (expect_it) begin
            if (sel7) begin q7.push_back(e); pushed7++; end
            else      begin q8.push_back(e); pushed8++; end
        end
        hold_rx(sel7, 1'b0, BIT_CLK);
        for (int i = 0; i < nbits; i++) hold_rx(sel7, data[i], BIT_CLK);
        hold_rx(sel7, stop_val, stop_clk);
        set_rx(sel7, 1'b1);
    endtask

    initial begin
        int wait_cnt;
        rst   = 1'b1;
        b8.rx = 1'b1;
        b7.rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_dout8", 32'(b8.dout), 32'(0));
        chk("reset_fe8", 32'(b8.frame_err), 32'(0));
        chk("reset_done8", 32'(b8.rx_done_tick), 32'(0));
        chk("reset_dout7", 32'(b7.dout), 32'(0));
        rst = 1'b0;
        hold_rx(1'b0, 1'b1, 40);

        // Clean 8N1 frame.
        send_frame(1'b0, 9'h0A5, 8, 1'b1, BIT_CLK, 1'b1);
        hold_rx(1'b0, 1'b1, 100);

        // Start-bit glitch: 5 s_ticks low must be rejected.
        hold_rx(1'b0, 1'b0, 20);
        hold_rx(1'b0, 1'b1, 200);
        chk("glitch_dout_held", 32'(b8.dout), 32'h0A5);
        chk("glitch_no_strobe", 32'(strobes8), 32'(1));

        // Bad stop bit: word still delivered, with framing error.
        send_frame(1'b0, 9'h03C, 8, 1'b0, 48, 1'b1);
        hold_rx(1'b0, 1'b1, 200);

        // Break: line low for a whole frame, then released.
        send_frame(1'b0, 9'h000, 8, 1'b0, 620 - 9 * BIT_CLK, 1'b1);
        hold_rx(1'b0, 1'b1, 200);
        chk("break_dout", 32'(b8.dout), 32'(0));
        chk("break_fe", 32'(b8.frame_err), 32'(1));

        // Back-to-back frames, no idle gap.
        send_frame(1'b0, 9'h000, 8, 1'b1, BIT_CLK, 1'b1);
        send_frame(1'b0, 9'h0FF, 8, 1'b1, BIT_CLK, 1'b1);
        hold_rx(1'b0, 1'b1, 100);

        // Reset in the middle of 0x96 (start + 3 data bits), then 0x5A.
        hold_rx(1'b0, 1'b0, BIT_CLK);
        hold_rx(1'b0, 1'b0, BIT_CLK);
        hold_rx(1'b0, 1'b1, BIT_CLK);
        hold_rx(1'b0, 1'b1, BIT_CLK);
        rst = 1'b1;
        set_rx(1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_dout", 32'(b8.dout), 32'(0));
        chk("midreset_fe", 32'(b8.frame_err), 32'(0));
        chk("midreset_done", 32'(b8.rx_done_tick), 32'(0));
        hold_rx(1'b0, 1'b1, 2 * BIT_CLK);
        send_frame(1'b0, 9'h05A, 8, 1'b1, BIT_CLK, 1'b1);
        hold_rx(1'b0, 1'b1, 100);

        // 7 data bits, 2 stop bits.
        send_frame(1'b1, 9'h041, 7, 1'b1, 2 * BIT_CLK, 1'b1);
        hold_rx(1'b1, 1'b1, 100);

        // Random words with random idle gaps on both receivers.
        for (int k = 0; k < 6; k++) begin
            send_frame(1'b0, 9'($urandom_range(0, 255)), 8, 1'b1, BIT_CLK, 1'b1);
            hold_rx(1'b0, 1'b1, $urandom_range(0, 100));
            send_frame(1'b1, 9'($urandom_range(0, 127)), 7, 1'b1, 2 * BIT_CLK, 1'b1);
            hold_rx(1'b1, 1'b1, $urandom_range(0, 100));
        end

        // Drain the scoreboards with a bounded wait.
        wait_cnt = 0;
        while ((q8.size() != 0 || q7.size() != 0) && wait_cnt < 2000) begin
            @(negedge clk);
            wait_cnt++;
        end
        n_cmp++;
        if (q8.size() != 0 || q7.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d/%0d frames pending expected 0/0", q8.size(), q7.size());
        end
        hold_rx(1'b0, 1'b1, 50);
        chk("strobe_count8", 32'(strobes8), 32'(pushed8));
        chk("strobe_count7", 32'(strobes7), 32'(pushed7));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive stage that sits directly downstream of the baud-rate tick generator. It consumes the 16x-oversampling tick `s_tick` and the asynchronous serial line `rx`, and recovers 8N1-style frames. Each received word is presented on `dout` with a one-cycle `rx_done_tick` strobe and a framing-error flag. The consumer is the UART RX FIFO or host logic.

## Interface
- `DBIT`, default 8: data bits per frame; legal range 5–9.
- `SB_TICK`, default 16: stop-bit length in s_ticks; legal values are 16, 24 and 32 (1, 1.5 and 2 stop bits).
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `s_tick`, input, 1: oversampling strobe, one `clk` wide, 16 per bit period. It is never asserted in two consecutive cycles.
- `rx`, input, 1: serial line, asynchronous to `clk`, idles high.
- `dout`, output, DBIT: last received word, LSB = first bit on the line.
- `rx_done_tick`, output, 1: one-cycle strobe; `dout` and `frame_err` are valid in this cycle.
- `frame_err`, output, 1: stop-bit sample of the last frame was 0.

## Operation
- `rx` passes through a 2-FF synchronizer whose flops reset to 1. `rx_s` denotes the synchronized output. All decisions use `rx_s`.
- The FSM has four states: IDLE, START, DATA, STOP. Registers:
  - `s`: 4-bit tick counter.
  - `n`: bit counter, $clog2(DBIT) bits.
  - `b`: DBIT-bit shift register.
- IDLE
  - When `rx_s`==0, go to START with `s`=0.
  - `s_tick` is ignored.
- START, on each `s_tick`:
  - If `s`==7 and `rx_s`==0: go to DATA with `s`=0, `n`=0. This is the start-bit midpoint.
  - If `s`==7 and `rx_s`==1: glitch; return to IDLE with no output.
  - Otherwise `s`++.
- DATA, on each `s_tick`:
  - If `s`==15: `s`=0 and `b` = {`rx_s`, `b`[DBIT-1:1]} (LSB first). Then, if `n`==DBIT-1, go to STOP; otherwise `n`++.
  - Otherwise `s`++.
- STOP, on each `s_tick`:
  - When `s`==15, capture `stop_bit`=`rx_s` (mid-point of the first stop bit).
  - When the tick count reaches SB_TICK-1, return to IDLE and, in the next cycle, make the frame visible:
    - `dout` <= `b`
    - `frame_err` <= ~`stop_bit`
    - `rx_done_tick` pulses.
  - For SB_TICK>16, `s` wraps and a separate 5-bit count tracks stop ticks. Alternatively widen `s` to 5 bits; either is acceptable.
- `dout` and `frame_err` hold their values until the next `rx_done_tick`.
- A frame with `frame_err`=1 still updates `dout` and still strobes.
- Break condition (`rx` held low): the frame completes with `frame_err`=1, then the FSM re-enters START immediately from IDLE. No lock-up.
- `rst` at any point:
  - FSM goes to IDLE; `s`, `n`, `b` go to 0.
  - `dout`=0, `rx_done_tick`=0, `frame_err`=0.
  - Synchronizer flops go to 1.
  - A partial frame is discarded.

## Timing
- Reset values: `dout`=0, `rx_done_tick`=0, `frame_err`=0, state IDLE.
- Latency from an `rx` falling edge to START entry is 2–3 `clk` (synchronizer).
- Data sampling lands at 8+16k ticks after start detection, i.e. mid-bit, tolerating ±7/16 bit of skew.
- `rx_done_tick` is registered. It is high exactly one `clk`, in the cycle after the `s_tick` that completes STOP.
- All state changes occur only on `s_tick` cycles, except IDLE→START.
- Frame length from START entry to strobe: 8 + 16·DBIT + SB_TICK s_ticks, plus 1 clk.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t`
  - `localparam int OVERSAMPLE = 16`
  - shared with the future `uart_tx`.
- Sub-module `sync_2ff` (parameterized reset value, default 1), instantiated for `rx`.
- Single registered FSM, with next-state logic in one combinational block.

## Test plan
All scenarios use `s_tick` = one pulse every 4 `clk`, fed from the baud generator with N=3.

- Send 0xA5 (DBIT=8, 1 stop) -> single `rx_done_tick`, `dout`=0xA5, `frame_err`=0.
- Pull `rx` low for 5 s_ticks, then high -> no strobe, FSM back in IDLE, `dout` unchanged.
- Send 0x3C with stop bit driven 0 -> `dout`=0x3C, `frame_err`=1, one strobe.
- Send back-to-back 0x00 then 0xFF with no idle gap -> two strobes ≥ (8+128+16)·4 clk apart, `dout` values 0x00 then 0xFF.
- Assert `rst` for one cycle after 3 data bits of 0x96, then send 0x5A -> outputs 0 after reset, then `dout`=0x5A and exactly one strobe.
- DBIT=7, SB_TICK=32: send 0x41 -> `dout`=0x41 with the strobe 32 s_ticks after STOP entry.
